// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - multi-channel timer sharing one prescaler, with per-channel pulse and sticky irq
module timer_multi #(
    parameter int  N_CH    = 4,
    parameter int  WIDTH   = 32,
    parameter int  PRESC_W = 8,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               presc_we,
    input  logic [PRESC_W-1:0] presc_val,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [WIDTH-1:0]   cfg_period,
    input  logic               cfg_oneshot,
    input  logic               cfg_arm,
    input  logic [N_CH-1:0]    irq_clr,
    output logic [N_CH-1:0]    pulse,
    output logic [N_CH-1:0]    running,
    output logic [N_CH-1:0]    irq_status
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    logic [PRESC_W-1:0] presc_reg_q, presc_reg_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               tick;

    ch_state_e          state_q  [N_CH];
    ch_state_e          state_d  [N_CH];
    logic [WIDTH-1:0]   cnt_q    [N_CH];
    logic [WIDTH-1:0]   cnt_d    [N_CH];
    logic [WIDTH-1:0]   period_q [N_CH];
    logic [WIDTH-1:0]   period_d [N_CH];
    logic [N_CH-1:0]    mode_q, mode_d;
    logic [N_CH-1:0]    pulse_q, pulse_d;
    logic [N_CH-1:0]    irq_q, irq_d;

    // Shared prescaler: a load restarts the divider and suppresses the tick for that cycle
    always_comb begin
        presc_reg_d = presc_reg_q;
        presc_cnt_d = presc_cnt_q;
        tick        = 1'b0;
        if (presc_we) begin
            presc_reg_d = presc_val;
            presc_cnt_d = '0;
        end else if (en) begin
            if (presc_cnt_q == presc_reg_q) begin
                tick        = 1'b1;
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_W'(1);
            end
        end
    end

    // Per-channel next state: a config write beats a same-cycle expiry, and expiry beats irq_clr
    always_comb begin
        mode_d  = mode_q;
        pulse_d = '0;
        irq_d   = irq_q & ~irq_clr;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                period_d[i] = cfg_period;
                mode_d[i]   = cfg_oneshot;
                cnt_d[i]    = '0;
                state_d[i]  = cfg_arm ? RUN : IDLE;
            end else if ((state_q[i] == RUN) && tick) begin
                if (cnt_q[i] >= period_q[i]) begin
                    cnt_d[i]   = '0;
                    pulse_d[i] = 1'b1;
                    irq_d[i]   = 1'b1;
                    if (mode_q[i]) begin
                        state_d[i] = IDLE;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    // Prescaler registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_reg_q <= '0;
            presc_cnt_q <= '0;
        end else begin
            presc_reg_q <= presc_reg_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= IDLE;
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
            mode_q  <= '0;
            pulse_q <= '0;
            irq_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
            irq_q   <= irq_d;
        end
    end

    // Output mapping
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            running[i] = (state_q[i] == RUN);
        end
    end

    assign pulse      = pulse_q;
    assign irq_status = irq_q;

endmodule

// File: doc/timer_multi.md
TIMER_MULTI -- requirements
Module: timer_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 32, bit width of per-channel period and counter.
REQ-003 SHALL have parameter PRESC_W, default 8, bit width of the shared prescaler.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 en  in  1  global enable; low freezes prescaler and all channel counters.
REQ-007 presc_we  in  1  load presc_val into prescaler register.
REQ-008 presc_val  in  PRESC_W  tick divider; a tick occurs every presc_val+1 enabled cycles.
REQ-009 cfg_we  in  1  channel configuration write strobe.
REQ-010 cfg_ch  in  max(1,$clog2(N_CH))  channel index for cfg_we; out-of-range index is ignored.
REQ-011 cfg_period  in  WIDTH  terminal count for the addressed channel.
REQ-012 cfg_oneshot  in  1  1 = one-shot mode, 0 = periodic mode.
REQ-013 cfg_arm  in  1  1 = arm (RUN) the channel, 0 = disarm (IDLE).
REQ-014 irq_clr  in  N_CH  per-channel write-1-to-clear for irq_status.
REQ-015 pulse  out  N_CH  registered one-cycle expiry pulse per channel.
REQ-016 running  out  N_CH  1 while the channel is in RUN.
REQ-017 irq_status  out  N_CH  sticky per-channel expiry flag.

Function
REQ-018 Prescaler counter SHALL count 0..presc_reg while en=1; tick = en && (presc_cnt == presc_reg); presc_cnt wraps to 0 on tick.
REQ-019 presc_we SHALL load presc_reg and zero presc_cnt; no tick is generated in that cycle.
REQ-020 Each channel SHALL have two states, IDLE and RUN, a WIDTH-bit cnt, a period register and a mode bit.
REQ-021 cfg_we SHALL load period and mode, zero cnt, set state RUN if cfg_arm else IDLE, in one cycle.
REQ-022 In RUN on tick: if cnt >= period then cnt <= 0 and pulse <= 1, else cnt <= cnt+1 and pulse <= 0.
REQ-023 Expiry thus occurs on every (period+1)-th tick; period=0 SHALL expire on every tick.
REQ-024 On expiry a periodic channel SHALL stay in RUN; a one-shot channel SHALL go to IDLE with cnt=0.
REQ-025 pulse SHALL be 0 in every cycle without an expiry, including all cycles in IDLE and all cycles with en=0.
REQ-026 Expiry SHALL set irq_status[i] on the same edge that sets pulse[i].
REQ-027 cfg_we to channel i in the same cycle as its expiry: configuration write wins; no pulse and no irq set.
REQ-028 irq_clr[i] together with expiry of channel i: set wins; irq_status[i] stays 1.
REQ-029 Counter arithmetic SHALL be unsigned WIDTH-bit; cnt never exceeds period, so it never wraps past 2**WIDTH-1.
REQ-030 cfg_we and irq_clr SHALL take effect regardless of en.
REQ-031 Channels SHALL be fully independent except for the shared tick.

Reset
REQ-032 rst=0 at a clock edge SHALL clear presc_reg, presc_cnt, all cnt, period and mode registers, pulse, running and irq_status to 0; all channels go to IDLE.
REQ-033 Reset SHALL take priority over en, cfg_we, presc_we and irq_clr, including during an active count.

Verification
REQ-034 presc_val=0, ch0 periodic, period=3, armed -> pulse[0] high every 4th cycle, single-cycle, running[0]=1 throughout.
REQ-035 presc_val=2, ch1 one-shot, period=1 -> exactly one pulse[1] 6 cycles after arming, then running[1]=0, irq_status[1]=1.
REQ-036 ch0 period=0 and ch2 period=5, presc_val=0 -> pulse[0] every cycle, pulse[2] every 6th cycle, no interference.
REQ-037 en deasserted for 10 cycles mid-count -> counters hold, no pulses; next pulse delayed by exactly 10 cycles.
REQ-038 irq_clr[0] asserted in the expiry cycle -> irq_status[0]=1 after the edge; irq_clr[0] alone on a later cycle -> 0.
REQ-039 rst=0 for one cycle while channels run -> all outputs 0 on the next cycle; no pulse until re-armed.
